// File: rtl/nor_nand_sweep_unit_pkg.sv
// Shared encodings for the N-input gate unit: gate modes, FSM states, size limits.
package nor_nand_sweep_unit_pkg;

  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_NAND = 3'd2;
  localparam logic [2:0] MODE_NOR  = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;

  localparam int N_MIN = 2;
  localparam int N_MAX = 6;

  // Code 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic bit n_legal(input int n);
    return (n >= N_MIN) && (n <= N_MAX);
  endfunction

endpackage

// File: rtl/nor_nand_sweep_unit_if.sv
// Host-facing bundle of the gate unit: control/operands in, gate and sweep results out.
interface nor_nand_sweep_unit_if #(parameter int N = 3);
  logic [2:0]          i_mode;
  logic [N-1:0]        i_a;
  logic                i_start;
  logic                o_busy;
  logic                o_done;
  logic [N-1:0]        o_vec;
  logic                o_y;
  logic [(1<<N)-1:0]   o_tbl;
  logic                o_tbl_valid;

  modport master (
    output i_mode, i_a, i_start,
    input  o_busy, o_done, o_vec, o_y, o_tbl, o_tbl_valid
  );

  modport slave (
    input  i_mode, i_a, i_start,
    output o_busy, o_done, o_vec, o_y, o_tbl, o_tbl_valid
  );
endinterface

// File: rtl/nor_nand_sweep_unit_nary_gate.sv
// Combinational N-input reduction gate; reserved modes drive 0.
module nary_gate
  import nor_nand_sweep_unit_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] i_v,
  input  logic [2:0]   i_m,
  output logic         o_f
);

  // Select one reduction of the full vector by mode.
  always_comb begin
    o_f = 1'b0;
    case (i_m)
      MODE_AND:  o_f = &i_v;
      MODE_OR:   o_f = |i_v;
      MODE_NAND: o_f = ~&i_v;
      MODE_NOR:  o_f = ~|i_v;
      MODE_XOR:  o_f = ^i_v;
      MODE_XNOR: o_f = ~^i_v;
      default:   o_f = 1'b0;
    endcase
  end

endmodule

// File: rtl/nor_nand_sweep_unit.sv
// N-input gate with registered output and a built-in exhaustive sweeper that
// captures the gate's truth table under a latched mode.
module nor_nand_sweep_unit
  import nor_nand_sweep_unit_pkg::*;
#(
  parameter int N        = 3,
  parameter int DEF_MODE = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  nor_nand_sweep_unit_if.slave    bus
);

  localparam int TW = 1 << N;

  generate
    if (!n_legal(N)) begin : g_bad_n
      $fatal(1, "nor_nand_sweep_unit: N must be in 2..6");
    end
  endgenerate

  state_t          r_state, w_next;
  logic [N-1:0]    r_cnt;
  logic [2:0]      r_mode_q;
  logic            r_y;
  logic [TW-1:0]   r_tbl;
  logic            r_tbl_valid;

  logic            w_sweep;
  logic            w_last;
  logic            w_start_acc;
  logic [N-1:0]    w_vec;
  logic [2:0]      w_mode;
  logic            w_f;

  assign w_sweep     = (r_state == ST_SWEEP);
  assign w_last      = &r_cnt;
  assign w_start_acc = (r_state == ST_IDLE) && bus.i_start;

  // One gate serves both paths: live operand in IDLE/DONE, counter under the frozen mode in SWEEP.
  assign w_vec  = w_sweep ? r_cnt    : bus.i_a;
  assign w_mode = w_sweep ? r_mode_q : bus.i_mode;

  nary_gate #(.N(N)) u_gate (
    .i_v (w_vec),
    .i_m (w_mode),
    .o_f (w_f)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: start only counts in IDLE; DONE always lasts exactly one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.i_start) w_next = ST_SWEEP;
      ST_SWEEP: if (w_last)      w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Datapath: counter, mode latch, output register and truth-table capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_mode_q    <= 3'(DEF_MODE);
      r_y         <= 1'b0;
      r_tbl       <= '0;
      r_tbl_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_y      <= w_f;
          r_mode_q <= bus.i_mode;
          if (w_start_acc) begin
            r_cnt       <= '0;
            r_tbl       <= '0;
            r_tbl_valid <= 1'b0;
          end
        end
        ST_SWEEP: begin
          r_tbl[r_cnt] <= w_f;
          r_y          <= w_f;
          // Counter parks at 0 after the last vector instead of wrapping mid-sweep.
          r_cnt        <= w_last ? '0 : r_cnt + 1'b1;
        end
        ST_DONE: begin
          r_tbl_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy      = w_sweep;
  assign bus.o_done      = (r_state == ST_DONE);
  assign bus.o_vec       = w_vec;
  assign bus.o_y         = r_y;
  assign bus.o_tbl       = r_tbl;
  assign bus.o_tbl_valid = r_tbl_valid;

endmodule

// File: tb/tb_nor_nand_sweep_unit.sv
// Directed bench for nor_nand_sweep_unit: an N=3 instance and an N=6 instance.
module tb_nor_nand_sweep_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   npass = 0;
  int   ntot  = 0;

  always #5 clk = ~clk;

  nor_nand_sweep_unit_if #(.N(3)) if3 ();
  nor_nand_sweep_unit_if #(.N(6)) if6 ();

  nor_nand_sweep_unit #(.N(3), .DEF_MODE(3)) u3 (.i_clk(clk), .i_rst(rst), .bus(if3));
  nor_nand_sweep_unit #(.N(6), .DEF_MODE(3)) u6 (.i_clk(clk), .i_rst(rst), .bus(if6));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) begin
      npass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch an N=3 sweep, observe a fixed 12-cycle window; optionally inject a
  // mode change plus start pulse at window index inj.
  task automatic sweep3(input logic [2:0] m, input int inj, input logic [2:0] inj_mode,
                        output int nbusy, output int ndone, output int done_at,
                        output bit vec_ok);
    if3.i_mode  = m;
    if3.i_start = 1'b1;
    tick();
    if3.i_start = 1'b0;
    nbusy = 0; ndone = 0; done_at = -1; vec_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (if3.o_busy) begin
        nbusy++;
        if (i < 8 && if3.o_vec !== 3'(i)) vec_ok = 1'b0;
      end
      if (if3.o_done) begin
        ndone++;
        done_at = i;
      end
      if (i == inj) begin
        if3.i_mode  = inj_mode;
        if3.i_start = 1'b1;
      end else begin
        if3.i_start = 1'b0;
      end
      tick();
    end
    if3.i_start = 1'b0;
  endtask

  initial begin
    int nb, nd, dat;
    bit vok;

    if3.i_mode = 3'd3; if3.i_a = 3'b000; if3.i_start = 1'b0;
    if6.i_mode = 3'd3; if6.i_a = 6'd0;   if6.i_start = 1'b0;

    // Reset state.
    rst = 1'b1;
    tick(); tick();
    chk("rst_busy",  64'(if3.o_busy), 64'd0);
    chk("rst_done",  64'(if3.o_done), 64'd0);
    chk("rst_y",     64'(if3.o_y), 64'd0);
    chk("rst_tbl",   64'(if3.o_tbl), 64'd0);
    chk("rst_tblv",  64'(if3.o_tbl_valid), 64'd0);
    chk("rst_tbl6",  if6.o_tbl, 64'd0);
    rst = 1'b0;

    // Idle pass-through NOR evaluation, one-cycle latency.
    if3.i_mode = 3'd3; if3.i_a = 3'b000;
    tick();
    chk("idle_y_000", 64'(if3.o_y), 64'd1);
    chk("idle_vec",   64'(if3.o_vec), 64'b000);
    if3.i_a = 3'b010;
    chk("idle_y_lat", 64'(if3.o_y), 64'd1);
    tick();
    chk("idle_y_010", 64'(if3.o_y), 64'd0);
    chk("idle_tbl",   64'(if3.o_tbl), 64'd0);
    if3.i_a = 3'b000;

    // NOR sweep.
    sweep3(3'd3, -1, 3'd0, nb, nd, dat, vok);
    chk("nor_busy",  64'(nb), 64'd8);
    chk("nor_done",  64'(nd), 64'd1);
    chk("nor_dat",   64'(dat), 64'd8);
    chk("nor_vec",   64'(vok), 64'd1);
    chk("nor_tbl",   64'(if3.o_tbl), 64'h01);
    chk("nor_tblv",  64'(if3.o_tbl_valid), 64'd1);

    // Idle evaluation afterwards leaves the table alone.
    if3.i_mode = 3'd1; if3.i_a = 3'b101;
    tick();
    chk("post_y_or",  64'(if3.o_y), 64'd1);
    chk("post_tbl",   64'(if3.o_tbl), 64'h01);
    chk("post_tblv",  64'(if3.o_tbl_valid), 64'd1);

    // NAND, XOR, reserved-mode sweeps.
    sweep3(3'd2, -1, 3'd0, nb, nd, dat, vok);
    chk("nand_tbl",  64'(if3.o_tbl), 64'h7F);
    chk("nand_busy", 64'(nb), 64'd8);
    sweep3(3'd4, -1, 3'd0, nb, nd, dat, vok);
    chk("xor_tbl",   64'(if3.o_tbl), 64'h96);
    sweep3(3'd6, -1, 3'd0, nb, nd, dat, vok);
    chk("m6_tbl",    64'(if3.o_tbl), 64'h00);
    chk("m6_tblv",   64'(if3.o_tbl_valid), 64'd1);
    sweep3(3'd5, -1, 3'd0, nb, nd, dat, vok);
    chk("xnor_tbl",  64'(if3.o_tbl), 64'h69);

    // Mode change and start mid-sweep are ignored.
    sweep3(3'd3, 3, 3'd0, nb, nd, dat, vok);
    chk("mid_tbl",   64'(if3.o_tbl), 64'h01);
    chk("mid_done",  64'(nd), 64'd1);
    chk("mid_busy",  64'(nb), 64'd8);

    // Start presented while DONE is ignored.
    sweep3(3'd0, 8, 3'd1, nb, nd, dat, vok);
    chk("dn_tbl",    64'(if3.o_tbl), 64'h80);
    chk("dn_busy",   64'(nb), 64'd8);
    chk("dn_done",   64'(nd), 64'd1);

    // Reset four cycles into a NOR sweep discards the partial table.
    if3.i_mode = 3'd3; if3.i_start = 1'b1;
    tick();
    if3.i_start = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_busy", 64'(if3.o_busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 64'(if3.o_busy), 64'd0);
    chk("mrst_tbl",  64'(if3.o_tbl), 64'd0);
    chk("mrst_tblv", 64'(if3.o_tbl_valid), 64'd0);
    chk("mrst_y",    64'(if3.o_y), 64'd0);
    sweep3(3'd2, -1, 3'd0, nb, nd, dat, vok);
    chk("rerun_tbl", 64'(if3.o_tbl), 64'h7F);
    chk("rerun_done",64'(nd), 64'd1);

    // N=6 OR sweep: 64 busy cycles then one done.
    if6.i_mode = 3'd1; if6.i_start = 1'b1;
    tick();
    if6.i_start = 1'b0;
    nb = 0; nd = 0;
    for (int i = 0; i < 70; i++) begin
      if (if6.o_busy) nb++;
      if (if6.o_done) nd++;
      tick();
    end
    chk("n6_busy",  64'(nb), 64'd64);
    chk("n6_done",  64'(nd), 64'd1);
    chk("n6_tbl",   if6.o_tbl, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("n6_tblv",  64'(if6.o_tbl_valid), 64'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
